// File: rtl/boot_word_assembler.sv
// Merges byte-lane Wishbone writes into 32-bit boot RAM words through a 2-entry word buffer.
// Optional running checksum of written words enabled by defining BOOT_ASM_CHECKSUM_EN.
module boot_word_assembler #(
  parameter int unsigned AWIDTH = 16
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [3:0]        wb_sel,
  input  logic [AWIDTH-1:0] wb_adr,
  input  logic [31:0]       wb_dat,
  input  logic              loader_done,
  output logic              ram_we,
  output logic [AWIDTH-3:0] ram_adr,
  output logic [31:0]       ram_dat,
  input  logic              ram_ready,
  output logic [AWIDTH-2:0] words_written,
  input  logic [31:0]       expected_sum,
  output logic [31:0]       checksum,
  output logic              boot_done,
  output logic              boot_ok,
  output logic              seq_err,
  output logic              overflow
);

  localparam int unsigned WAW  = AWIDTH - 2;
  localparam int unsigned CNTW = AWIDTH - 1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WAW-1:0]    cur_wadr_q, cur_wadr_d;
  logic [31:0]       asm_dat_q, asm_dat_d;
  logic [3:0]        asm_vld_q, asm_vld_d;
  // FIFO head lives directly in ram_we/ram_adr/ram_dat; entry 1 is the tail slot
  logic              f1_vld_q, f1_vld_d;
  logic [WAW-1:0]    f1_adr_q, f1_adr_d;
  logic [31:0]       f1_dat_q, f1_dat_d;
  logic              f0_vld_d;
  logic [WAW-1:0]    f0_adr_d;
  logic [31:0]       f0_dat_d;
  logic [CNTW-1:0]   words_d;
  logic [31:0]       sum_d;
  logic              seq_d, ovf_d, done_d, ok_d;

  logic              byte_acc, sel_ok, pop;
  logic [1:0]        lane;
  logic [7:0]        byte_val;
  logic [WAW-1:0]    byte_wadr;
  logic [3:0]        wv;
  logic [31:0]       wd;
  logic [1:0]              push_v;
  logic [1:0][WAW-1:0]     push_adr;
  logic [1:0][31:0]        push_dat;

`ifdef BOOT_ASM_CHECKSUM_EN
  logic unused_lsb;
  assign unused_lsb = ^wb_adr[1:0];
`else
  logic unused_lsb;
  assign unused_lsb = ^{wb_adr[1:0], expected_sum};
`endif

  // Next lane expected in order: lowest lane not yet written.
  function automatic logic [1:0] first_free(input logic [3:0] v);
    if (!v[0]) return 2'd0;
    if (!v[1]) return 2'd1;
    if (!v[2]) return 2'd2;
    return 2'd3;
  endfunction

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q       <= ST_LOAD;
      cur_wadr_q    <= '0;
      asm_dat_q     <= '0;
      asm_vld_q     <= '0;
      ram_we        <= 1'b0;
      ram_adr       <= '0;
      ram_dat       <= '0;
      f1_vld_q      <= 1'b0;
      f1_adr_q      <= '0;
      f1_dat_q      <= '0;
      words_written <= '0;
      checksum      <= '0;
      seq_err       <= 1'b0;
      overflow      <= 1'b0;
      boot_done     <= 1'b0;
      boot_ok       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_wadr_q    <= cur_wadr_d;
      asm_dat_q     <= asm_dat_d;
      asm_vld_q     <= asm_vld_d;
      ram_we        <= f0_vld_d;
      ram_adr       <= f0_adr_d;
      ram_dat       <= f0_dat_d;
      f1_vld_q      <= f1_vld_d;
      f1_adr_q      <= f1_adr_d;
      f1_dat_q      <= f1_dat_d;
      words_written <= words_d;
      checksum      <= sum_d;
      seq_err       <= seq_d;
      overflow      <= ovf_d;
      boot_done     <= done_d;
      boot_ok       <= ok_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_wadr_d = cur_wadr_q;
    asm_dat_d  = asm_dat_q;
    asm_vld_d  = asm_vld_q;
    f0_vld_d   = ram_we;
    f0_adr_d   = ram_adr;
    f0_dat_d   = ram_dat;
    f1_vld_d   = f1_vld_q;
    f1_adr_d   = f1_adr_q;
    f1_dat_d   = f1_dat_q;
    words_d    = words_written;
    sum_d      = checksum;
    seq_d      = seq_err;
    ovf_d      = overflow;
    push_v     = '0;
    push_adr   = '0;
    push_dat   = '0;
    byte_acc   = wb_stb & wb_we;
    byte_wadr  = wb_adr[AWIDTH-1:2];
    wv         = asm_vld_q;
    wd         = asm_dat_q;
    pop        = ram_we & ram_ready;
    sel_ok     = 1'b1;
    lane       = 2'd0;
    byte_val   = wb_dat[31:24];

    case (wb_sel)
      4'b1000: begin lane = 2'd0; byte_val = wb_dat[31:24]; end
      4'b0100: begin lane = 2'd1; byte_val = wb_dat[23:16]; end
      4'b0010: begin lane = 2'd2; byte_val = wb_dat[15:8];  end
      4'b0001: begin lane = 2'd3; byte_val = wb_dat[7:0];   end
      default: sel_ok = 1'b0;
    endcase

    case (state_q)
      ST_LOAD: begin
        if (byte_acc && !sel_ok) begin
          seq_d = 1'b1;
        end else if (byte_acc) begin
          // Address moved off the open word: emit it zero-filled and restart
          if (wv != 4'd0 && byte_wadr != cur_wadr_q) begin
            push_v[0]   = 1'b1;
            push_adr[0] = cur_wadr_q;
            push_dat[0] = wd;
            seq_d       = 1'b1;
            wv          = '0;
            wd          = '0;
          end
          if (lane != first_free(wv))
            seq_d = 1'b1;
          wv[lane] = 1'b1;
          case (lane)
            2'd0:    wd[31:24] = byte_val;
            2'd1:    wd[23:16] = byte_val;
            2'd2:    wd[15:8]  = byte_val;
            default: wd[7:0]   = byte_val;
          endcase
          cur_wadr_d = byte_wadr;
          if (lane == 2'd3) begin
            push_v[1]   = 1'b1;
            push_adr[1] = byte_wadr;
            push_dat[1] = wd;
            wv          = '0;
            wd          = '0;
          end
          asm_vld_d = wv;
          asm_dat_d = wd;
        end
        if (loader_done)
          state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (byte_acc)
          seq_d = 1'b1;
        if (asm_vld_q != 4'd0) begin
          push_v[0]   = 1'b1;
          push_adr[0] = cur_wadr_q;
          push_dat[0] = asm_dat_q;
          seq_d       = 1'b1;
          asm_vld_d   = '0;
          asm_dat_d   = '0;
        end
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (byte_acc)
          seq_d = 1'b1;
        if (!ram_we)
          state_d = ST_DONE;
      end
      default: begin
        if (byte_acc)
          seq_d = 1'b1;
      end
    endcase

    // Pop frees the head before any push lands, so push+pop while full is lossless
    if (pop) begin
      words_d = words_written + CNTW'(1);
`ifdef BOOT_ASM_CHECKSUM_EN
      sum_d   = checksum + ram_dat;
`endif
      f0_vld_d = f1_vld_q;
      f0_adr_d = f1_adr_q;
      f0_dat_d = f1_dat_q;
      f1_vld_d = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (push_v[i]) begin
        if (!f0_vld_d) begin
          f0_vld_d = 1'b1;
          f0_adr_d = push_adr[i];
          f0_dat_d = push_dat[i];
        end else if (!f1_vld_d) begin
          f1_vld_d = 1'b1;
          f1_adr_d = push_adr[i];
          f1_dat_d = push_dat[i];
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    done_d = (state_d == ST_DONE);
`ifdef BOOT_ASM_CHECKSUM_EN
    ok_d = done_d & ~seq_d & ~ovf_d & (sum_d == expected_sum);
`else
    ok_d = done_d & ~seq_d & ~ovf_d;
`endif
  end

endmodule

// File: tb/tb_boot_word_assembler.sv
// Scoreboard bench for boot_word_assembler: random byte streams against a queue-based reference model.
module tb_boot_word_assembler;

  logic        clk;
  logic        rst_n;
  logic        stb, we, ld, rdy;
  logic [3:0]  sel;
  logic [15:0] adr;
  logic [31:0] dat;
  logic        ram_we;
  logic [13:0] ram_adr;
  logic [31:0] ram_dat;
  logic [14:0] ww;
  logic [31:0] exp_sum;
  logic [31:0] checksum;
  logic        boot_done, boot_ok, seq_err, overflow;

  boot_word_assembler #(.AWIDTH(16)) dut (
    .wb_clk        (clk),
    .wb_rst_n      (rst_n),
    .wb_stb        (stb),
    .wb_we         (we),
    .wb_sel        (sel),
    .wb_adr        (adr),
    .wb_dat        (dat),
    .loader_done   (ld),
    .ram_we        (ram_we),
    .ram_adr       (ram_adr),
    .ram_dat       (ram_dat),
    .ram_ready     (rdy),
    .words_written (ww),
    .expected_sum  (exp_sum),
    .checksum      (checksum),
    .boot_done     (boot_done),
    .boot_ok       (boot_ok),
    .seq_err       (seq_err),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: assembly bytes, buffered word queue (capacity 2), flags, counters
  int          m_phase;
  bit [3:0]    m_vld;
  logic [7:0]  m_byte [4];
  int unsigned m_cur;
  int unsigned mq_adr [$];
  logic [31:0] mq_dat [$];
  int unsigned sb_adr [$];
  logic [31:0] sb_dat [$];
  int unsigned log_adr [$];
  logic [31:0] log_dat [$];
  bit          m_seq, m_ovf;
  int unsigned m_ww;
  logic [31:0] m_sum;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_word();
    return {m_vld[0] ? m_byte[0] : 8'h00, m_vld[1] ? m_byte[1] : 8'h00,
            m_vld[2] ? m_byte[2] : 8'h00, m_vld[3] ? m_byte[3] : 8'h00};
  endfunction

  task automatic model_push(input int unsigned a, input logic [31:0] d);
    if (mq_adr.size() < 2) begin
      mq_adr.push_back(a);
      mq_dat.push_back(d);
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_clear();
    m_phase = 0; m_vld = '0; m_cur = 0; m_seq = 0; m_ovf = 0; m_ww = 0; m_sum = '0;
    mq_adr.delete(); mq_dat.delete(); sb_adr.delete(); sb_dat.delete();
    log_adr.delete(); log_dat.delete();
  endtask

  task automatic model_step(input bit s, input bit w, input logic [3:0] sl,
                            input int unsigned a, input logic [7:0] b, input bit l, input bit r);
    bit was_empty;
    bit acc;
    int lane;
    int expl;
    int unsigned wa;
    int unsigned pa;
    logic [31:0] pd;
    was_empty = (mq_adr.size() == 0);
    acc = s & w;
    if (!was_empty && r) begin
      pa = mq_adr.pop_front();
      pd = mq_dat.pop_front();
      sb_adr.push_back(pa);
      sb_dat.push_back(pd);
      m_ww  = (m_ww + 1) % 32768;
      m_sum = m_sum + pd;
    end
    case (m_phase)
      0: begin
        if (acc) begin
          if (!$onehot(sl)) begin
            m_seq = 1'b1;
          end else begin
            lane = (sl == 4'b1000) ? 0 : (sl == 4'b0100) ? 1 : (sl == 4'b0010) ? 2 : 3;
            wa = a / 4;
            if (m_vld != 0 && wa != m_cur) begin
              model_push(m_cur, m_word());
              m_seq = 1'b1;
              m_vld = '0;
            end
            expl = 3;
            for (int i = 3; i >= 0; i--) if (!m_vld[i]) expl = i;
            if (lane != expl) m_seq = 1'b1;
            m_byte[lane] = b;
            m_vld[lane]  = 1'b1;
            m_cur = wa;
            if (lane == 3) begin
              model_push(wa, m_word());
              m_vld = '0;
            end
          end
        end
        if (l) m_phase = 1;
      end
      1: begin
        if (acc) m_seq = 1'b1;
        if (m_vld != 0) begin
          model_push(m_cur, m_word());
          m_seq = 1'b1;
          m_vld = '0;
        end
        m_phase = 2;
      end
      2: begin
        if (acc) m_seq = 1'b1;
        if (was_empty) m_phase = 3;
      end
      default: if (acc) m_seq = 1'b1;
    endcase
  endtask

  // One bus cycle: lockstep status checks, then drive inputs and advance the model.
  task automatic cycle(input bit s, input bit w, input logic [3:0] sl, input int unsigned a,
                       input logic [7:0] b, input bit l, input bit r);
    @(posedge clk);
    #1;
    check("ram_we", {31'd0, ram_we}, {31'd0, mq_adr.size() != 0});
    check("boot_done", {31'd0, boot_done}, {31'd0, m_phase == 3});
    check("seq_err", {31'd0, seq_err}, {31'd0, m_seq});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("words_written", {17'd0, ww}, m_ww);
`ifdef BOOT_ASM_CHECKSUM_EN
    check("checksum", checksum, m_sum);
`else
    check("checksum", checksum, 32'd0);
`endif
    stb = s; we = w; sel = sl; adr = 16'(a); dat = {4{b}}; ld = l; rdy = r;
    model_step(s, w, sl, a, b, l, r);
  endtask

  task automatic idle(input bit r);
    cycle(1'b0, 1'b0, 4'b0000, 0, 8'h00, 1'b0, r);
  endtask

  task automatic send_word(input int unsigned wadr, input logic [31:0] wrd, input bit r);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, 4'(4'b1000 >> i), wadr * 4 + i, wrd[31 - 8*i -: 8], 1'b0, r);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
    check({tag, "_words"}, {17'd0, ww}, 32'd0);
    check({tag, "_seq_err"}, {31'd0, seq_err}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, "_boot_done"}, {31'd0, boot_done}, 32'd0);
    check({tag, "_boot_ok"}, {31'd0, boot_ok}, 32'd0);
    check({tag, "_checksum"}, checksum, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    stb = 0; we = 0; sel = 0; adr = 0; dat = 0; ld = 0; rdy = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_zero("reset");
  endtask

  task automatic finish_episode(input int p, input bit force_exp, input logic [31:0] ev);
    int guard;
    bit exp_ok;
    guard = 0;
    while (m_phase != 3 && guard < 400) begin
      cycle(($urandom % 20) == 0, 1'b1, 4'b1000, 0, 8'h5A, 1'b1, ($urandom % 100) < p);
      guard++;
    end
    check("drain_timeout", {31'd0, m_phase == 3}, 32'd1);
    exp_sum = force_exp ? ev : (($urandom % 2) ? m_sum : m_sum + 32'd1);
    idle(1'b1);
    exp_ok = !m_seq && !m_ovf;
`ifdef BOOT_ASM_CHECKSUM_EN
    exp_ok = exp_ok && (exp_sum == m_sum);
`endif
    check("final_boot_done", {31'd0, boot_done}, 32'd1);
    check("final_boot_ok", {31'd0, boot_ok}, {31'd0, exp_ok});
    check("sb_drained", sb_adr.size(), 32'd0);
  endtask

  // Monitor: every DUT word write is compared against the next expected word.
  always @(negedge clk) begin
    if (rst_n && ram_we && rdy) begin
      log_adr.push_back(32'(ram_adr));
      log_dat.push_back(ram_dat);
      if (sb_adr.size() == 0) begin
        check("unexpected_write", {18'd0, ram_adr}, 32'hFFFF_FFFF);
      end else begin
        check("ram_adr", {18'd0, ram_adr}, sb_adr.pop_front());
        check("ram_dat", ram_dat, sb_dat.pop_front());
      end
    end
  end

  initial begin
    int p;
    int n;
    int unsigned pos;
    int m;
    bit r;
    logic [7:0] b;
    logic [3:0] bad;

    rst_n = 1'b0;
    stb = 0; we = 0; sel = 0; adr = 0; dat = 0; ld = 0; rdy = 0; exp_sum = 0;
    model_clear();

    // Clean load: word one cycle after the last byte
    do_reset();
    send_word(0, 32'h11223344, 1'b1);
    idle(1'b1);
    check("clean_ram_we", {31'd0, ram_we}, 32'd1);
    check("clean_ram_adr", {18'd0, ram_adr}, 32'd0);
    check("clean_ram_dat", ram_dat, 32'h11223344);
    idle(1'b1);
    check("clean_words", {17'd0, ww}, 32'd1);
    finish_episode(100, 1'b1, 32'h11223344);
    check("clean_boot_ok", {31'd0, boot_ok}, 32'd1);

    // Stall: third word dropped
    do_reset();
    send_word(0, 32'hA0A1A2A3, 1'b0);
    send_word(1, 32'hB0B1B2B3, 1'b0);
    send_word(2, 32'hC0C1C2C3, 1'b0);
    idle(1'b0);
    check("stall_overflow", {31'd0, overflow}, 32'd1);
    check("stall_head", ram_dat, 32'hA0A1A2A3);
    finish_episode(100, 1'b0, 32'd0);
    check("stall_boot_ok", {31'd0, boot_ok}, 32'd0);

    // Partial flush
    do_reset();
    cycle(1'b1, 1'b1, 4'b1000, 8, 8'hAA, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 4'b0100, 9, 8'hBB, 1'b0, 1'b1);
    finish_episode(100, 1'b0, 32'd0);
    check("flush_cnt", log_dat.size(), 32'd1);
    if (log_dat.size() >= 1) begin
      check("flush_adr", log_adr[0], 32'd2);
      check("flush_dat", log_dat[0], 32'hAABB0000);
    end
    check("flush_seq_err", {31'd0, seq_err}, 32'd1);

    // Address jump
    do_reset();
    cycle(1'b1, 1'b1, 4'b1000, 0, 8'h55, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 4'b0100, 1, 8'h66, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 4'b1000, 4, 8'h77, 1'b0, 1'b1);
    finish_episode(100, 1'b0, 32'd0);
    check("jump_cnt", log_dat.size(), 32'd2);
    if (log_dat.size() >= 2) begin
      check("jump_dat0", log_dat[0], 32'h55660000);
      check("jump_adr0", log_adr[0], 32'd0);
      check("jump_adr1", log_adr[1], 32'd1);
      check("jump_dat1", log_dat[1], 32'h77000000);
    end

`ifdef BOOT_ASM_CHECKSUM_EN
    // Checksum wraps to zero
    do_reset();
    send_word(0, 32'h00000001, 1'b1);
    send_word(1, 32'hFFFFFFFF, 1'b1);
    finish_episode(100, 1'b1, 32'd0);
    check("cksum_value", checksum, 32'd0);
    check("cksum_ok", {31'd0, boot_ok}, 32'd1);
    do_reset();
    send_word(0, 32'h00000001, 1'b1);
    send_word(1, 32'hFFFFFFFF, 1'b1);
    finish_episode(100, 1'b1, 32'd1);
    check("cksum_bad", {31'd0, boot_ok}, 32'd0);
`endif

    // Asynchronous reset with one word buffered and a partial word open
    do_reset();
    send_word(0, 32'h01020304, 1'b1);
    idle(1'b1);
    cycle(1'b1, 1'b1, 4'b0011, 4, 8'h00, 1'b0, 1'b0);
    send_word(1, 32'hCAFEF00D, 1'b0);
    cycle(1'b1, 1'b1, 4'b1000, 8, 8'h77, 1'b0, 1'b0);
    idle(1'b0);
    check("pre_rst_ram_we", {31'd0, ram_we}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async");
    model_clear();
    rdy = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) idle(1'b1);

    // Randomized loads
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      case ($urandom % 3)
        0: p = 100;
        1: p = 60;
        default: p = 15;
      endcase
      n = $urandom_range(4, 28);
      pos = $urandom_range(0, 200) * 4;
      for (int k = 0; k < n; k++) begin
        r = ($urandom % 100) < p;
        m = $urandom % 16;
        b = 8'($urandom);
        case (m)
          0: idle(r);
          1: cycle(1'b1, 1'b0, 4'(4'b1000 >> (pos % 4)), pos, b, 1'b0, r);
          2: begin
            case ($urandom % 4)
              0: bad = 4'b0000;
              1: bad = 4'b0011;
              2: bad = 4'b1100;
              default: bad = 4'b1111;
            endcase
            cycle(1'b1, 1'b1, bad, pos, b, 1'b0, r);
          end
          3: begin
            cycle(1'b1, 1'b1, 4'(4'b1000 >> ($urandom % 4)), pos, b, 1'b0, r);
            pos++;
          end
          4: pos = $urandom_range(0, 200) * 4 + ($urandom % 4);
          default: begin
            cycle(1'b1, 1'b1, 4'(4'b1000 >> (pos % 4)), pos, b, 1'b0, r);
            pos++;
          end
        endcase
      end
      finish_episode((p < 20) ? 20 : p, 1'b0, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/boot_word_assembler.md
# boot_word_assembler

Downstream consumer of the CPLD firmware loader's byte-wide Wishbone write stream, in the `wb_clk` domain. It merges the four byte-lane writes of each 32-bit word into a single word write toward the boot RAM port, absorbing short RAM stalls in a 2-entry word buffer. It checks byte ordering and reports completion, plus an optional checksum, so the CPU reset can be released only after a clean load.

## Interface
- `AWIDTH`, 16: byte-address width of the incoming stream; word address is `AWIDTH-2` bits.
- `wb_clk` in 1: sole clock.
- `wb_rst_n` in 1: reset, asynchronous, active-low.
- `wb_stb` in 1: byte write strobe; one byte per cycle when high, no backpressure.
- `wb_we` in 1: write qualifier; a byte is accepted only when `wb_stb & wb_we`.
- `wb_sel` in 4: byte lane, one-hot.
- `wb_adr` in AWIDTH: byte address.
- `wb_dat` in 32: data; the byte is replicated on all lanes.
- `loader_done` in 1: level; upstream load finished.
- `ram_we` out 1: word write request.
- `ram_adr` out AWIDTH-2: word address.
- `ram_dat` out 32: word data.
- `ram_ready` in 1: RAM accepts the word this cycle.
- `words_written` out AWIDTH-1: count of words popped to RAM.
- `expected_sum` in 32: reference checksum, static during load.
- `checksum` out 32: running checksum.
- `boot_done` out 1: all words written to RAM.
- `boot_ok` out 1: load succeeded.
- `seq_err` out 1: sticky ordering error.
- `overflow` out 1: sticky word drop.

## Operation
- **Lane map (big-endian):** `wb_sel` 1000→lane0→`[31:24]`, 0100→lane1→`[23:16]`, 0010→lane2→`[15:8]`, 0001→lane3→`[7:0]`.
- **Assembly register:** holds the current word address `cur_wadr`, 32-bit data, and a 4-bit `valid` mask.
- **Accepted byte rules:**
  - Non-one-hot `wb_sel`: byte ignored, `seq_err` set.
  - `valid`≠0 and `wb_adr[AWIDTH-1:2]`≠`cur_wadr`: push the partial word with missing bytes zero, set `seq_err`, then start a new word with this byte.
  - Lane not the next expected one (lane0 on an empty word, otherwise lowest unset lane): byte stored anyway, `seq_err` set.
  - Lane3 stored: push the word, clear `valid`.
- **Word FIFO:** 2 entries of {addr, data}.
  - `ram_we` = ~empty; `ram_adr`/`ram_dat` show the FIFO head.
  - Pop when `ram_we & ram_ready`.
  - Push while full with no pop in the same cycle: word dropped, `overflow` set.
  - Simultaneous push and pop while full is legal.
- **States:**
  - LOAD → FLUSH when `loader_done`=1.
  - FLUSH: push any partial word (zero-filled; `seq_err` set if `valid`≠0), → DRAIN. Bytes arriving in FLUSH or later are ignored and set `seq_err`.
  - DRAIN → DONE when FIFO empty.
  - DONE: terminal until reset.
- **Counters:** `words_written` increments on each pop and wraps modulo 2^(AWIDTH-1).
- **Outputs in DONE:** `boot_done`=1; `boot_ok`=`boot_done & ~seq_err & ~overflow` (& checksum match, see Configuration).

## Timing
- **Reset:** all outputs 0; FIFO empty; state LOAD; `valid`=0.
- **Word latency:** lane3 byte accepted in cycle N → `ram_we`=1 in N+1 with the FIFO empty.
- **Pop effects:** pop in cycle M → `words_written` and `checksum` update at end of M, visible in M+1.
- **Flush/drain:** `loader_done` sampled high in cycle K → FLUSH in K+1 → DRAIN in K+2 → earliest `boot_done` in K+3 (FIFO already empty and no partial word).
- **Reset mid-load:** asynchronous clear of everything. No RAM write is issued after reset assertion, and the in-flight word is lost.

## Configuration
- `BOOT_ASM_CHECKSUM_EN` defined:
  - `checksum` += popped word, modulo 2^32.
  - `boot_ok` additionally requires `checksum == expected_sum`.
- Undefined:
  - `checksum` tied to 0 and `expected_sum` ignored.
  - `boot_ok` depends only on `boot_done`, `seq_err` and `overflow`.

## Test plan
- **Clean load:** bytes 0x11,0x22,0x33,0x44 at addr 0..3 with lanes 1000..0001, `ram_ready`=1 → one write {adr 0, 0x11223344} one cycle after the last byte; `words_written`=1.
- **Stall and overflow:** `ram_ready`=0, 3 complete words streamed (addr 0..11) → first two buffered, third dropped, `overflow`=1; `boot_ok`=0 after `loader_done`.
- **Partial flush:** bytes 0xAA,0xBB at addr 8,9, then `loader_done` → write {adr 2, 0xAABB0000}; `seq_err`=1; `boot_done`=1 ≥3 cycles later.
- **Address jump:** lane0/lane1 at addr 0,1, then lane0 at addr 4 → word {0, 0xXXYY0000} pushed, `seq_err`=1, new word started at adr 1.
- **Checksum (macro on):** words 0x00000001 and 0xFFFFFFFF, `expected_sum`=0 → `checksum`=0, `boot_ok`=1. With `expected_sum`=1 → `boot_ok`=0.
- **Async reset:** assert `wb_rst_n`=0 mid-word with the FIFO holding 1 entry → `ram_we`, `words_written` and all flags read 0 immediately, with no clock edge needed.
